// File: rtl/id_ex_if.sv
// ID -> EX pipeline register bus: stall/flush/bubble controls plus the stage payload.
// ID_EX_BUBBLE_CNT_EN adds the bubble_cnt_o performance counter output.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall_i;
    logic              flush_i;
    logic              bubble_i;
    logic [1:0]        ALUOp_i,    ALUOp_o;
    logic              ALUSrc_i,   ALUSrc_o;
    logic              Branch_i,   Branch_o;
    logic              MemRead_i,  MemRead_o;
    logic              MemWrite_i, MemWrite_o;
    logic              RegWrite_i, RegWrite_o;
    logic              MemtoReg_i, MemtoReg_o;
    logic [DATA_W-1:0] RS1data_i,  RS1data_o;
    logic [DATA_W-1:0] RS2data_i,  RS2data_o;
    logic [DATA_W-1:0] Imm_i,      Imm_o;
    logic [9:0]        funct_i,    funct_o;
    logic [4:0]        RS1addr_i,  RS1addr_o;
    logic [4:0]        RS2addr_i,  RS2addr_o;
    logic [4:0]        RDaddr_i,   RDaddr_o;
    logic              valid_o;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0]  bubble_cnt_o;
`else
    if (CNT_W < 1) begin : gCntWUnused
    end
`endif

    modport master (
        output stall_i, flush_i, bubble_i,
        output ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i,
        output RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o,
        input  RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
`ifdef ID_EX_BUBBLE_CNT_EN
        input  bubble_cnt_o,
`endif
        input  valid_o
    );

    modport slave (
        input  stall_i, flush_i, bubble_i,
        input  ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i,
        input  RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o,
        output RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
`ifdef ID_EX_BUBBLE_CNT_EN
        output bubble_cnt_o,
`endif
        output valid_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and load-use bubble marking.
// Define ID_EX_BUBBLE_CNT_EN to compile in the saturating bubble counter.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic    clk_i,
    input logic    rst_i,
    id_ex_if.slave bus
);
    logic [1:0]               aluOp_p1;
    logic                     aluSrc_p1, branch_p1, memRead_p1, memWrite_p1;
    logic                     regWrite_p1, memtoReg_p1, valid_p1;
    logic signed [DATA_W-1:0] rs1Data_p1, rs2Data_p1, imm_p1;
    logic [9:0]               funct_p1;
    logic [4:0]               rs1Addr_p1, rs2Addr_p1, rdAddr_p1;
    logic                     killCtrl;
    logic                     killData;

    // Control is forced low locally so a missed upstream zeroing cannot leak side effects.
    assign killCtrl = bus.flush_i | bus.bubble_i;
    assign killData = bus.flush_i;

    // ID -> EX stage boundary
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            aluOp_p1    <= '0;
            aluSrc_p1   <= 1'b0;
            branch_p1   <= 1'b0;
            memRead_p1  <= 1'b0;
            memWrite_p1 <= 1'b0;
            regWrite_p1 <= 1'b0;
            memtoReg_p1 <= 1'b0;
            valid_p1    <= 1'b0;
            rs1Data_p1  <= '0;
            rs2Data_p1  <= '0;
            imm_p1      <= '0;
            funct_p1    <= '0;
            rs1Addr_p1  <= '0;
            rs2Addr_p1  <= '0;
            rdAddr_p1   <= '0;
        end else if (!bus.stall_i) begin
            aluOp_p1    <= killCtrl ? 2'b00 : bus.ALUOp_i;
            aluSrc_p1   <= ~killCtrl & bus.ALUSrc_i;
            branch_p1   <= ~killCtrl & bus.Branch_i;
            memRead_p1  <= ~killCtrl & bus.MemRead_i;
            memWrite_p1 <= ~killCtrl & bus.MemWrite_i;
            regWrite_p1 <= ~killCtrl & bus.RegWrite_i;
            memtoReg_p1 <= ~killCtrl & bus.MemtoReg_i;
            valid_p1    <= ~killCtrl;
            // A flushed slot clears RD as well so the forwarding unit never matches it.
            rs1Data_p1  <= killData ? '0 : bus.RS1data_i;
            rs2Data_p1  <= killData ? '0 : bus.RS2data_i;
            imm_p1      <= killData ? '0 : bus.Imm_i;
            funct_p1    <= killData ? '0 : bus.funct_i;
            rs1Addr_p1  <= killData ? '0 : bus.RS1addr_i;
            rs2Addr_p1  <= killData ? '0 : bus.RS2addr_i;
            rdAddr_p1   <= killData ? '0 : bus.RDaddr_i;
        end
    end

    assign bus.ALUOp_o    = aluOp_p1;
    assign bus.ALUSrc_o   = aluSrc_p1;
    assign bus.Branch_o   = branch_p1;
    assign bus.MemRead_o  = memRead_p1;
    assign bus.MemWrite_o = memWrite_p1;
    assign bus.RegWrite_o = regWrite_p1;
    assign bus.MemtoReg_o = memtoReg_p1;
    assign bus.valid_o    = valid_p1;
    assign bus.RS1data_o  = rs1Data_p1;
    assign bus.RS2data_o  = rs2Data_p1;
    assign bus.Imm_o      = imm_p1;
    assign bus.funct_o    = funct_p1;
    assign bus.RS1addr_o  = rs1Addr_p1;
    assign bus.RS2addr_o  = rs2Addr_p1;
    assign bus.RDaddr_o   = rdAddr_p1;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubbleCnt_p1;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Bubble counter, same edge as the bubble it counts
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubbleCnt_p1 <= '0;
        end else if (!bus.stall_i && killCtrl) begin
            bubbleCnt_p1 <= satInc(bubbleCnt_p1);
        end
    end

    assign bus.bubble_cnt_o = bubbleCnt_p1;
`else
    if (CNT_W < 1) begin : gCntWUnused
    end
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// Directed + randomized bench for id_ex_register against a priority-rule reference model.
module tb_id_ex_register;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int DATA_BITS = 3 * DW + 25;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    id_ex_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    id_ex_register #(.DATA_W(DW), .CNT_W(CW)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: what EX should currently see
    logic [8:0]           eCtrl;
    logic [DATA_BITS-1:0] eData;
    logic                 eValid;
    int                   eCnt;

    function automatic logic [8:0] inCtrl();
        return {bus.ALUOp_i, bus.ALUSrc_i, bus.Branch_i, bus.MemRead_i,
                bus.MemWrite_i, bus.RegWrite_i, bus.MemtoReg_i};
    endfunction

    function automatic logic [DATA_BITS-1:0] inData();
        return {bus.RS1data_i, bus.RS2data_i, bus.Imm_i, bus.funct_i,
                bus.RS1addr_i, bus.RS2addr_i, bus.RDaddr_i};
    endfunction

    function automatic logic [8:0] outCtrl();
        return {bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.MemRead_o,
                bus.MemWrite_o, bus.RegWrite_o, bus.MemtoReg_o};
    endfunction

    function automatic logic [DATA_BITS-1:0] outData();
        return {bus.RS1data_o, bus.RS2data_o, bus.Imm_o, bus.funct_o,
                bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o};
    endfunction

    task automatic checkVec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkVec({tag, "-ctrl"}, 128'(outCtrl()), 128'(eCtrl));
        checkVec({tag, "-data"}, 128'(outData()), 128'(eData));
        checkVec({tag, "-valid"}, 128'(bus.valid_o), 128'(eValid));
`ifdef ID_EX_BUBBLE_CNT_EN
        checkVec({tag, "-cnt"}, 128'(bus.bubble_cnt_o), 128'(eCnt));
`endif
    endtask

    task automatic modelReset();
        eCtrl = '0; eData = '0; eValid = 1'b0; eCnt = 0;
    endtask

    // One rising edge under the priority stall > flush > bubble > load
    task automatic modelEdge();
        if (!bus.stall_i) begin
            if (bus.flush_i) begin
                eCtrl = '0; eData = '0; eValid = 1'b0;
            end else if (bus.bubble_i) begin
                eCtrl = '0; eData = inData(); eValid = 1'b0;
            end else begin
                eCtrl = inCtrl(); eData = inData(); eValid = 1'b1;
            end
            if ((bus.flush_i || bus.bubble_i) && eCnt < (1 << CW) - 1) eCnt = eCnt + 1;
        end
    endtask

    task automatic randInputs();
        bus.ALUOp_i    = 2'($urandom);
        bus.ALUSrc_i   = 1'($urandom);
        bus.Branch_i   = 1'($urandom);
        bus.MemRead_i  = 1'($urandom);
        bus.MemWrite_i = 1'($urandom);
        bus.RegWrite_i = 1'($urandom);
        bus.MemtoReg_i = 1'($urandom);
        bus.RS1data_i  = DW'($urandom);
        bus.RS2data_i  = DW'($urandom);
        bus.Imm_i      = DW'($urandom);
        bus.funct_i    = 10'($urandom);
        bus.RS1addr_i  = 5'($urandom);
        bus.RS2addr_i  = 5'($urandom);
        bus.RDaddr_i   = 5'($urandom);
    endtask

    task automatic setCtl(input logic s, input logic f, input logic b);
        bus.stall_i = s; bus.flush_i = f; bus.bubble_i = b;
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic tick(input string tag);
        #1;
        checkAll({tag, "-pre"});
        modelEdge();
        @(posedge clk_i);
        #1;
        checkAll(tag);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        setCtl(1'b0, 1'b0, 1'b0);
        randInputs();
        modelReset();
        @(negedge clk_i);
        @(negedge clk_i);
        checkAll("reset");
        rst_i = 1'b1;

        // Normal pass
        randInputs();
        bus.ALUOp_i = 2'b10; bus.RDaddr_i = 5'd5; bus.Imm_i = 32'hFFFF_FFF0;
        tick("normal");
        checkVec("normal-imm", 128'(bus.Imm_o), 128'(32'hFFFF_FFF0));

        // Reset between edges clears outputs immediately
        randInputs();
        bus.RS1data_i = 32'h1234_5678; bus.RegWrite_i = 1'b1;
        tick("preReset");
        checkVec("preReset-rs1", 128'(bus.RS1data_o), 128'(32'h1234_5678));
        #2 rst_i = 1'b0;
        modelReset();
        #1 checkAll("asyncReset");
        @(posedge clk_i);
        #1 checkAll("resetHeld");
        @(negedge clk_i);
        rst_i = 1'b1;
        randInputs();
        tick("firstLoad");

        // Stall hold while inputs change and flush/bubble pulse
        randInputs(); setCtl(1'b1, 1'b0, 1'b0); tick("stall1");
        randInputs(); setCtl(1'b1, 1'b1, 1'b0); tick("stall2");
        randInputs(); setCtl(1'b1, 1'b0, 1'b1); tick("stall3");
        randInputs(); setCtl(1'b0, 1'b0, 1'b0); tick("release");

        // Flush
        randInputs(); bus.MemWrite_i = 1'b1; bus.RDaddr_i = 5'd7;
        setCtl(1'b0, 1'b1, 1'b0); tick("flush");
        checkVec("flush-rd", 128'(bus.RDaddr_o), 128'(0));

        // Load-use bubble with control not zeroed upstream
        randInputs(); bus.RegWrite_i = 1'b1; bus.RS1addr_i = 5'd3;
        setCtl(1'b0, 1'b0, 1'b1); tick("bubble");
        checkVec("bubble-rs1a", 128'(bus.RS1addr_o), 128'(3));
        randInputs(); setCtl(1'b0, 1'b1, 1'b1); tick("flushBubble");

        // Saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            randInputs(); setCtl(1'b0, 1'b0, 1'b1); tick("sat");
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        checkVec("sat-cnt", 128'(bus.bubble_cnt_o), 128'(3));
`endif

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            randInputs();
            setCtl(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 3) == 0));
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
